// File: rtl/fb_access_sched.sv
// Framebuffer access scheduler: VGA scan-out reads take priority, rectangle fills use idle slots.
// Latency: read address issued one pixel ahead, RGB valid in the pixel's own cycle; fill writes start the cycle after accept.
// Backpressure: cmd_ready low while a fill (or the optional reset clear) runs; a stalled fill holds all counters.
// Optional feature macro FB_CLEAR_ON_RESET_EN: after reset the whole RAM is cleared to CLEAR_RGB before commands are taken.
module fb_access_sched #(
   parameter int          FB_W       = 240,
   parameter int          FB_H       = 180,
   parameter int          HPIXELS    = 800,
   parameter int          HBP        = 344,
   parameter int          HFP        = 584,
   parameter int          VBP        = 181,
   parameter int          VFP        = 361,
   parameter logic [11:0] BORDER_RGB = 12'hFFF,
   parameter logic [11:0] CLEAR_RGB  = 12'h000
) (
   input  logic        dclk,
   input  logic        clr_n,
   input  logic [9:0]  hc,
   input  logic [9:0]  vc,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_x,
   input  logic [7:0]  cmd_y,
   input  logic [7:0]  cmd_w,
   input  logic [7:0]  cmd_h,
   input  logic [11:0] cmd_rgb,
   output logic        busy,
   output logic        fill_done,
   output logic [15:0] ram_addr,
   output logic        ram_we,
   output logic [11:0] ram_wdata,
   input  logic [11:0] ram_rdata,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue
);

   localparam logic [9:0]  HLAST_V = 10'(HPIXELS - 1);
   localparam logic [9:0]  HBP_V   = 10'(HBP);
   localparam logic [9:0]  HFP_V   = 10'(HFP);
   localparam logic [9:0]  VBP_V   = 10'(VBP);
   localparam logic [9:0]  VFP_V   = 10'(VFP);
   localparam logic [7:0]  FB_W8   = 8'(FB_W);
   localparam logic [7:0]  FB_H8   = 8'(FB_H);
   localparam logic [15:0] FB_W16  = 16'(FB_W);
`ifdef FB_CLEAR_ON_RESET_EN
   localparam logic [15:0] LAST_ADDR = 16'(FB_W * FB_H - 1);
`endif

`ifdef FB_CLEAR_ON_RESET_EN
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_CLEAR} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
`endif

   state_t      state, state_nxt;

   // scan-out lookahead
   logic [9:0]  hn;
   logic [9:0]  hoff;
   logic [9:0]  vrow;
   logic        read_slot;
   logic        rd_pend;
   logic [15:0] rd_addr;

   // fill engine
   logic [15:0] wr_addr;
   logic [15:0] row_base;
   logic [7:0]  x_cnt;
   logic [7:0]  y_cnt;
   logic [7:0]  w_eff;
   logic [7:0]  h_eff;
   logic [11:0] fill_rgb;
   logic        last_col;
   logic        last_row;
   logic        wr_en;
   logic        accept;

   // command decode at accept
   logic        cmd_bad;
   logic [7:0]  rem_w;
   logic [7:0]  rem_h;
   logic [7:0]  clip_w;
   logic [7:0]  clip_h;
   logic [15:0] start_addr;

   logic [11:0] rgb;

`ifdef FB_CLEAR_ON_RESET_EN
   logic        clr_start;
`endif

   // Read slot uses next pixel's column so the synchronous RAM data lands in the pixel's own cycle.
   always_comb begin
      hn        = (hc == HLAST_V) ? 10'd0 : hc + 10'd1;
      read_slot = (vc >= VBP_V) && (vc < VFP_V) && (hn >= HBP_V) && (hn < HFP_V);
      hoff      = hn - HBP_V;
      vrow      = vc - VBP_V;
      rd_addr   = 16'(hoff) + 16'(vrow) * FB_W16;
   end

   // Validate and clip the incoming rectangle against the framebuffer edges.
   always_comb begin
      cmd_bad    = (cmd_x >= FB_W8) || (cmd_y >= FB_H8) || (cmd_w == 8'd0) || (cmd_h == 8'd0);
      rem_w      = FB_W8 - cmd_x;
      rem_h      = FB_H8 - cmd_y;
      clip_w     = (cmd_w < rem_w) ? cmd_w : rem_w;
      clip_h     = (cmd_h < rem_h) ? cmd_h : rem_h;
      start_addr = 16'(cmd_y) * FB_W16 + 16'(cmd_x);
      last_col   = (x_cnt == w_eff - 8'd1);
      last_row   = (y_cnt == h_eff - 8'd1);
   end

   // State register.
   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

`ifdef FB_CLEAR_ON_RESET_EN
   // One-shot request that steers the first post-reset cycle into the clear sweep.
   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) clr_start <= 1'b1;
      else        clr_start <= 1'b0;
   end
`endif

   // Next-state and handshake/write-strobe decode.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      fill_done = 1'b0;
      wr_en     = 1'b0;
      case (state)
         S_IDLE: begin
            busy      = 1'b0;
            cmd_ready = 1'b1;
`ifdef FB_CLEAR_ON_RESET_EN
            if (clr_start) begin
               busy      = 1'b1;
               cmd_ready = 1'b0;
               state_nxt = S_CLEAR;
            end else
`endif
            if (cmd_valid) state_nxt = cmd_bad ? S_DONE : S_FILL;
         end
         S_FILL: begin
            if (!read_slot) begin
               wr_en = 1'b1;
               if (last_col && last_row) state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            fill_done = 1'b1;
            state_nxt = S_IDLE;
         end
`ifdef FB_CLEAR_ON_RESET_EN
         S_CLEAR: begin
            if (!read_slot) begin
               wr_en = 1'b1;
               if (wr_addr == LAST_ADDR) state_nxt = S_IDLE;
            end
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
      accept = cmd_ready && cmd_valid;
   end

   // RAM port mux: scan-out owns the port in read slots, the fill/clear engine otherwise.
   always_comb begin
      ram_we    = wr_en;
      ram_addr  = read_slot ? rd_addr : wr_addr;
      ram_wdata = (state == S_FILL) ? fill_rgb : CLEAR_RGB;
   end

   // Fill counters: latched on accept, advanced only on granted write slots; row step is add-only.
   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         wr_addr  <= '0;
         row_base <= '0;
         x_cnt    <= '0;
         y_cnt    <= '0;
         w_eff    <= '0;
         h_eff    <= '0;
         fill_rgb <= '0;
      end else if (accept) begin
         wr_addr  <= start_addr;
         row_base <= start_addr;
         x_cnt    <= '0;
         y_cnt    <= '0;
         w_eff    <= clip_w;
         h_eff    <= clip_h;
         fill_rgb <= cmd_rgb;
      end else if (wr_en) begin
         if (state == S_FILL) begin
            if (last_col) begin
               x_cnt    <= '0;
               y_cnt    <= y_cnt + 8'd1;
               row_base <= row_base + FB_W16;
               wr_addr  <= row_base + FB_W16;
            end else begin
               x_cnt    <= x_cnt + 8'd1;
               wr_addr  <= wr_addr + 16'd1;
            end
         end else begin
            wr_addr <= wr_addr + 16'd1;
         end
      end
   end

   // Remember that last cycle issued a scan-out read, so this cycle's RAM data is a pixel.
   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) rd_pend <= 1'b0;
      else        rd_pend <= read_slot;
   end

   // Pixel output: RAM data inside the window, border colour elsewhere.
   always_comb begin
      rgb   = rd_pend ? ram_rdata : BORDER_RGB;
      red   = rgb[11:8];
      green = rgb[7:4];
      blue  = rgb[3:0];
   end

endmodule

// File: tb/tb_fb_access_sched.sv
`timescale 1ns/1ps
module tb_fb_access_sched;

   logic        dclk = 1'b0;
   logic        clr_n;
   logic [9:0]  hc, vc;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_x, cmd_y, cmd_w, cmd_h;
   logic [11:0] cmd_rgb;
   logic        busy, fill_done;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [11:0] ram_wdata, ram_rdata;
   logic [3:0]  red, green, blue;

   fb_access_sched dut (
      .dclk(dclk), .clr_n(clr_n), .hc(hc), .vc(vc),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_rgb(cmd_rgb),
      .busy(busy), .fill_done(fill_done),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .red(red), .green(green), .blue(blue)
   );

   always #5 dclk = ~dclk;

   // synchronous single-port RAM model, preloaded with addr=data on its first clock
   logic [11:0] mem [0:43199];
   logic        loaded = 1'b0;
   always @(posedge dclk) begin
      if (!loaded) begin
         for (int i = 0; i < 43200; i++) mem[i] <= 12'(i);
         loaded <= 1'b1;
      end else begin
         if (ram_we && ram_addr < 16'd43200) mem[ram_addr] <= ram_wdata;
         ram_rdata <= (ram_addr < 16'd43200) ? mem[ram_addr] : 12'h000;
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit tgen   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // independent read-slot model
   function automatic bit tb_rslot(input logic [9:0] h, input logic [9:0] v);
      int hn;
      hn = (h == 10'd799) ? 0 : int'(h) + 1;
      return (v >= 10'd181) && (v < 10'd361) && (hn >= 344) && (hn < 584);
   endfunction

   // write monitor
   int wq_addr[$], wq_data[$], wq_cyc[$], wq_hc[$];
   int viol     = 0;
   int done_cnt = 0;
   always @(negedge dclk) begin
      if (ram_we === 1'b1) begin
         wq_addr.push_back(int'(ram_addr));
         wq_data.push_back(int'(ram_wdata));
         wq_cyc.push_back(cyc);
         wq_hc.push_back(int'(hc));
         if (tb_rslot(hc, vc)) viol++;
      end
      if (fill_done === 1'b1) done_cnt++;
   end

   task automatic clr_q();
      wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); wq_hc.delete();
   endtask

   // advance one clock; inputs change 1ns after the edge
   task automatic tick();
      @(posedge dclk);
      #1;
      cyc++;
      if (tgen) begin
         if (hc == 10'd799) begin
            hc = 10'd0;
            vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
         end else begin
            hc = hc + 10'd1;
         end
      end
   endtask

   // present a command and hold it until accepted; returns the first cycle after accept
   task automatic send_cmd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                           input logic [7:0] h, input logic [11:0] c, output int acc_cyc);
      bit ok = 1'b0;
      cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_rgb = c; cmd_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge dclk);
         if (cmd_ready === 1'b1) begin
            tick();
            cmd_valid = 1'b0;
            ok = 1'b1;
            break;
         end
         tick();
      end
      acc_cyc = cyc;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   // wait (bounded) for fill_done; returns with time at the negedge of the done cycle
   task automatic wait_done(input int limit, input string tag, output int dcyc);
      bit ok = 1'b0;
      dcyc = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge dclk);
         if (fill_done === 1'b1) begin
            ok = 1'b1;
            dcyc = cyc;
            break;
         end
         tick();
      end
      chk(tag, ok, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, dc, w0, d0;
      logic [11:0] exp_rgb;
      clr_n = 1'b0; hc = '0; vc = '0; cmd_valid = 1'b0;
      cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_rgb = '0;

      // reset state
      #3;
`ifdef FB_CLEAR_ON_RESET_EN
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 1);
`else
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
`endif
      chk("rst_fill_done", fill_done, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_rgb", {red, green, blue}, 12'hFFF);
      tick(); tick();
      clr_n = 1'b1;

`ifdef FB_CLEAR_ON_RESET_EN
      w0 = wq_addr.size();
      for (int i = 0; i < 50000; i++) begin
         @(negedge dclk);
         if (cmd_ready === 1'b1) break;
         tick();
      end
      chk("clear_writes", wq_addr.size() - w0, 43200);
      chk("clear_last", wq_addr[wq_addr.size()-1], 43199);
      tick();
`endif
      clr_q();

      // scan-out sweep on the first active line
      vc = 10'd181; hc = 10'd342;
      tick();
      for (int h = 343; h <= 585; h++) begin
         hc = 10'(h);
         @(negedge dclk);
         if (h <= 582) chk("sweep_addr", ram_addr, h - 343);
         if (h == 343 || h == 500 || h == 582) chk("sweep_we", ram_we, 0);
`ifdef FB_CLEAR_ON_RESET_EN
         exp_rgb = (h >= 344 && h <= 583) ? 12'h000 : 12'hFFF;
`else
         exp_rgb = (h >= 344 && h <= 583) ? 12'(h - 344) : 12'hFFF;
`endif
         chk("sweep_rgb", {red, green, blue}, exp_rgb);
         tick();
      end

      // basic fill during vertical blank
      vc = 10'd0; hc = 10'd0;
      clr_q();
      send_cmd(8'd10, 8'd20, 8'd3, 8'd2, 12'h0F0, acc);
      cmd_x = 8'd99; cmd_y = 8'd99; cmd_w = 8'd99; cmd_h = 8'd99; cmd_rgb = 12'hBAD;
      wait_done(100, "fill1_done", dc);
      chk("fill1_count", wq_addr.size(), 6);
      chk("fill1_a0", wq_addr[0], 4810);
      chk("fill1_a1", wq_addr[1], 4811);
      chk("fill1_a2", wq_addr[2], 4812);
      chk("fill1_a3", wq_addr[3], 5050);
      chk("fill1_a4", wq_addr[4], 5051);
      chk("fill1_a5", wq_addr[5], 5052);
      chk("fill1_d5", wq_data[5], 12'h0F0);
      chk("fill1_first_cyc", wq_cyc[0], acc);
      chk("fill1_span", wq_cyc[5] - wq_cyc[0], 5);
      chk("fill1_done_cyc", dc, wq_cyc[5] + 1);
      chk("fill1_busy_done", busy, 1);
      tick();
      @(negedge dclk);
      chk("fill1_ready_after", cmd_ready, 1);
      chk("fill1_done_pulse", fill_done, 0);
      tick();

      // clipped fill at the bottom-right corner
      clr_q();
      send_cmd(8'd230, 8'd175, 8'd50, 8'd50, 12'hABC, acc);
      wait_done(200, "clip_done", dc);
      chk("clip_count", wq_addr.size(), 50);
      chk("clip_first", wq_addr[0], 42230);
      chk("clip_row2", wq_addr[10], 42470);
      chk("clip_last", wq_addr[49], 43199);
      tick();

      // fill across an active line: writes only outside read slots
      clr_q();
      viol = 0;
      hc = 10'd340; vc = 10'd200; tgen = 1'b1;
      send_cmd(8'd0, 8'd50, 8'd240, 8'd1, 12'h00F, acc);
      wait_done(1000, "line_done", dc);
      tgen = 1'b0;
      chk("line_count", wq_addr.size(), 240);
      chk("line_hc0", wq_hc[0], 341);
      chk("line_a0", wq_addr[0], 12000);
      chk("line_hc1", wq_hc[1], 342);
      chk("line_hc2", wq_hc[2], 583);
      chk("line_a2", wq_addr[2], 12002);
      chk("line_last", wq_addr[239], 12239);
      chk("line_no_we_in_read", viol, 0);
      tick();

      // rejected command, then a second command held through DONE
      vc = 10'd0; hc = 10'd0;
      clr_q();
      cmd_x = 8'd240; cmd_y = 8'd0; cmd_w = 8'd5; cmd_h = 8'd5; cmd_rgb = 12'h777; cmd_valid = 1'b1;
      @(negedge dclk);
      chk("bad_ready", cmd_ready, 1);
      tick();
      cmd_x = 8'd0; cmd_y = 8'd0; cmd_w = 8'd1; cmd_h = 8'd1; cmd_rgb = 12'h123;
      @(negedge dclk);
      chk("bad_done", fill_done, 1);
      chk("bad_busy", busy, 1);
      chk("bad_ready_busy", cmd_ready, 0);
      tick();
      @(negedge dclk);
      chk("bad_no_writes", wq_addr.size(), 0);
      chk("bad_idle_ready", cmd_ready, 1);
      chk("bad_done_once", fill_done, 0);
      tick();
      cmd_valid = 1'b0;
      @(negedge dclk);
      chk("px_we", ram_we, 1);
      chk("px_addr", ram_addr, 0);
      chk("px_data", ram_wdata, 12'h123);
      tick();
      wait_done(20, "px_done", dc);
      chk("px_count", wq_addr.size(), 1);
      tick();

      // reset in the middle of a stalled fill
      clr_q();
      send_cmd(8'd0, 8'd100, 8'd240, 8'd10, 12'h555, acc);
      repeat (5) tick();
      vc = 10'd181; hc = 10'd400;
      tick();
      @(negedge dclk);
      chk("stall_we", ram_we, 0);
`ifdef FB_CLEAR_ON_RESET_EN
      chk("stall_rgb", {red, green, blue}, 12'h000);
`else
      chk("stall_rgb", {red, green, blue}, 12'd57);
`endif
      chk("pre_rst_writes", wq_addr.size(), 5);
      d0 = done_cnt;
      #2;
      clr_n = 1'b0;
      #1;
`ifdef FB_CLEAR_ON_RESET_EN
      chk("mid_rst_busy", busy, 1);
`else
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", cmd_ready, 1);
`endif
      chk("mid_rst_we", ram_we, 0);
      chk("mid_rst_rgb", {red, green, blue}, 12'hFFF);
      chk("mid_rst_done", fill_done, 0);
      tick(); tick();
      vc = 10'd0; hc = 10'd0;
      clr_n = 1'b1;
      repeat (20) tick();
      @(negedge dclk);
      chk("post_rst_no_done", done_cnt - d0, 0);
`ifdef FB_CLEAR_ON_RESET_EN
      chk("post_rst_clearing", busy, 1);
`else
      chk("post_rst_no_writes", wq_addr.size(), 5);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ready", cmd_ready, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
